// File: rtl/str_byte_streamer.sv
// Serialises a right-justified packed string into a valid/ready byte stream.
// NUL bytes (leading padding and embedded) are skipped at one cycle each.
module str_byte_streamer #(
   parameter int MAX_LEN = 16,
   parameter int CW      = $clog2(MAX_LEN + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic [8*MAX_LEN-1:0] str_i,
   output logic                 busy_o,
   output logic                 tvalid_o,
   output logic [7:0]           tdata_o,
   output logic                 tlast_o,
   input  logic                 tready_i,
   output logic                 done_o,
   output logic [CW-1:0]        count_o
);

   localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SCAN = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state;
   logic [7:0]    shadow [MAX_LEN];
   logic [IW-1:0] idx;
   logic [IW-1:0] last_idx;
   logic [IW-1:0] in_last;
   logic          in_any;
   logic [7:0]    cur_byte;
   logic          cur_nz;

   // Position of the final non-NUL character is found once at capture so
   // tlast_o is a simple index compare during streaming.
   always_comb begin
      in_last = '0;
      in_any  = 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if (str_i[8*(MAX_LEN-1-i) +: 8] != 8'h00) begin
            in_last = IW'(i);
            in_any  = 1'b1;
         end
      end
   end

   always_comb begin
      cur_byte = shadow[idx];
      cur_nz   = (cur_byte != 8'h00);
   end

   // All outputs decode registered state only; tready_i never reaches them.
   always_comb begin
      busy_o   = (state != S_IDLE);
      done_o   = (state == S_DONE);
      tvalid_o = (state == S_SCAN) && cur_nz;
      tdata_o  = (state == S_SCAN) ? cur_byte : 8'h00;
      tlast_o  = tvalid_o && (idx == last_idx);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         idx      <= '0;
         last_idx <= '0;
         count_o  <= '0;
         for (int i = 0; i < MAX_LEN; i++) begin
            shadow[i] <= 8'h00;
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  for (int i = 0; i < MAX_LEN; i++) begin
                     shadow[i] <= str_i[8*(MAX_LEN-1-i) +: 8];
                  end
                  last_idx <= in_last;
                  idx      <= '0;
                  count_o  <= '0;
                  state    <= in_any ? S_SCAN : S_DONE;
               end
            end
            S_SCAN: begin
               if (!cur_nz) begin
                  idx <= idx + IW'(1);
               end else if (tready_i) begin
                  count_o <= count_o + CW'(1);
                  // The final character ends the scan; idx stays in range.
                  if (idx == last_idx) begin
                     state <= S_DONE;
                  end else begin
                     idx <= idx + IW'(1);
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_str_byte_streamer.sv
// Randomised bench for str_byte_streamer against a transaction-level string model.
module tb_str_byte_streamer;

   localparam int ML = 16;
   localparam int CW = $clog2(ML + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          start_i;
   logic [8*ML-1:0] str_i;
   logic          busy_o;
   logic          tvalid_o;
   logic [7:0]    tdata_o;
   logic          tlast_o;
   logic          tready_i;
   logic          done_o;
   logic [CW-1:0] count_o;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_count = 0;

   always #5 clk = ~clk;

   str_byte_streamer #(.MAX_LEN(ML), .CW(CW)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .str_i(str_i),
      .busy_o(busy_o), .tvalid_o(tvalid_o), .tdata_o(tdata_o),
      .tlast_o(tlast_o), .tready_i(tready_i), .done_o(done_o),
      .count_o(count_o)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [8*ML-1:0] pack(input string s);
      logic [8*ML-1:0] r;
      r = '0;
      for (int i = 0; i < s.len(); i++) r[8*(s.len()-1-i) +: 8] = s[i];
      return r;
   endfunction

   // Reference: the stream is the non-NUL bytes in order; byte position p is
   // reached at cycle 1+p plus all stall cycles seen so far.
   task automatic stream(input string name, input logic [8*ML-1:0] s,
                         input int ready_pct, input bit poke);
      logic [7:0] ch_q[$];
      int         pos_q[$];
      logic [7:0] b;
      int c, k, stalls, first_c, done_c, lead, lastpos;
      bit prev_stall, fin;
      logic [7:0] prev_data;
      logic prev_last;

      for (int i = 0; i < ML; i++) begin
         b = s[8*(ML-1-i) +: 8];
         if (b != 8'h00) begin
            ch_q.push_back(b);
            pos_q.push_back(i);
         end
      end
      lead    = (pos_q.size() > 0) ? pos_q[0] : -1;
      lastpos = (pos_q.size() > 0) ? pos_q[pos_q.size()-1] : -1;

      @(negedge clk);
      check({name, "_idle_busy"}, busy_o, 0);
      check({name, "_prev_count"}, count_o, exp_count);
      start_i  = 1'b1;
      str_i    = s;
      tready_i = ($urandom_range(99) < ready_pct);
      @(posedge clk);
      #1;
      start_i = 1'b0;
      str_i   = {$urandom(), $urandom(), $urandom(), $urandom()};

      c = 0; k = 0; stalls = 0; first_c = -1; done_c = -1;
      prev_stall = 1'b0; fin = 1'b0; prev_data = 8'h00; prev_last = 1'b0;
      while (!fin && c < 4*ML + 16) begin
         @(negedge clk);
         c++;
         tready_i = ($urandom_range(99) < ready_pct);
         check({name, "_busy"}, busy_o, 1);
         if (prev_stall) begin
            check({name, "_hold_valid"}, tvalid_o, 1);
            check({name, "_hold_data"}, tdata_o, prev_data);
            check({name, "_hold_last"}, tlast_o, prev_last);
         end
         prev_stall = 1'b0;
         if (done_o) begin
            done_c = c;
            fin    = 1'b1;
            check({name, "_valid_in_done"}, tvalid_o, 0);
         end else if (tvalid_o) begin
            if (first_c < 0) first_c = c;
            if (tready_i) begin
               if (k < ch_q.size()) begin
                  check({name, "_data"}, tdata_o, ch_q[k]);
                  check({name, "_last"}, tlast_o, (k == ch_q.size()-1));
                  check({name, "_beat_cycle"}, c, 1 + pos_q[k] + stalls);
               end else begin
                  check({name, "_extra_beat"}, 1, 0);
               end
               k++;
            end else begin
               stalls++;
               prev_stall = 1'b1;
               prev_data  = tdata_o;
               prev_last  = tlast_o;
            end
         end
         if (poke && c == 2 && !fin) begin
            start_i = 1'b1;
            str_i   = ~s;
         end else begin
            start_i = 1'b0;
         end
      end

      if (!fin) begin
         check({name, "_timeout"}, 0, 1);
      end else begin
         check({name, "_count"}, count_o, ch_q.size());
         check({name, "_beats"}, k, ch_q.size());
         if (ch_q.size() == 0) begin
            check({name, "_empty_done"}, done_c, 1);
            check({name, "_empty_novalid"}, first_c, -1);
         end else begin
            check({name, "_first"}, first_c, lead + 1);
            check({name, "_done"}, done_c, lastpos + 2 + stalls);
         end
      end
      exp_count = ch_q.size();
      start_i = 1'b0;
      if (poke) begin
         start_i = 1'b1;
         str_i   = ~s;
         @(posedge clk);
         #1;
         start_i = 1'b0;
      end
   endtask

   initial begin
      logic [8*ML-1:0] s;
      bit fin;

      rst = 1'b1; start_i = 1'b0; tready_i = 1'b0; str_i = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_busy", busy_o, 0);
      check("rst_valid", tvalid_o, 0);
      check("rst_data", tdata_o, 0);
      check("rst_last", tlast_o, 0);
      check("rst_done", done_o, 0);
      check("rst_count", count_o, 0);

      stream("hello_world", pack("Hello world!"), 100, 1'b0);
      stream("empty", '0, 100, 1'b0);
      stream("after_empty", pack("ok"), 100, 1'b0);
      s = (pack("hello") << 48) | pack("world");
      stream("embedded_nul", s, 100, 1'b0);
      stream("abc_bp", pack("ABC"), 50, 1'b0);
      stream("poke", pack("busy test"), 70, 1'b1);

      // Reset while 'l' of "hello" is stalled.
      @(negedge clk);
      start_i = 1'b1; str_i = pack("hello"); tready_i = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
      fin = 1'b0;
      for (int c = 0; c < 40 && !fin; c++) begin
         @(negedge clk);
         if (tvalid_o && tdata_o == 8'h6c) begin
            tready_i = 1'b0;
            fin = 1'b1;
         end else begin
            tready_i = 1'b1;
         end
      end
      check("rstmid_reached_l", fin, 1);
      @(negedge clk);
      check("rstmid_stall_valid", tvalid_o, 1);
      check("rstmid_stall_data", tdata_o, 8'h6c);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rstmid_busy", busy_o, 0);
      check("rstmid_valid", tvalid_o, 0);
      check("rstmid_data", tdata_o, 0);
      check("rstmid_last", tlast_o, 0);
      check("rstmid_done", done_o, 0);
      check("rstmid_count", count_o, 0);
      exp_count = 0;
      stream("after_rst", pack("hi"), 100, 1'b0);

      for (int t = 0; t < 20; t++) begin
         for (int i = 0; i < ML; i++) begin
            s[8*i +: 8] = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom_range(126, 33));
         end
         if (t == 5) s = '0;
         stream("rand", s, $urandom_range(100, 20), 1'($urandom_range(1)));
      end

      @(negedge clk);
      check("final_idle", busy_o, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
